// File: rtl/uart_pkg.sv
// Shared UART definitions: parity type encoding (common with the TX parity
// calculator) and the receive FSM state encoding.
package uart_pkg;

  localparam logic EVEN_PAR = 1'b0;
  localparam logic ODD_PAR  = 1'b1;

  // Oversampling ratio used when PRESCALE is not one of 8/16/32.
  localparam int PRESCALE_FALLBACK = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority-vote sampler. Captures the synchronized line at
// edge_cnt = P/2-1, P/2 and P/2+1 of every bit period. The voted bit is
// stable from edge_cnt = P/2+2 until the next bit's first capture.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_s_i,
  input  logic [PRESCALE_W-1:0] edge_cnt_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bit_o,
  output logic                  valid_o
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] half;
  logic [2:0]            smp_q, smp_d;

  assign half = prescale_i >> 1;

  // Pick up each of the three capture points as the edge counter passes them.
  always_comb begin
    smp_d = smp_q;
    if (edge_cnt_i == half - ONE) smp_d[0] = rx_s_i;
    if (edge_cnt_i == half)       smp_d[1] = rx_s_i;
    if (edge_cnt_i == half + ONE) smp_d[2] = rx_s_i;
  end

  // Sample registers idle high, like the line itself.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) smp_q <= '1;
    else      smp_q <= smp_d;
  end

  assign bit_o   = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  assign valid_o = (edge_cnt_i >= half + TWO);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF input synchronizer, frame FSM with edge and bit
// counters, LSB-first shift register, parity/stop checks and registered
// one-cycle result strobes.
// Line handshake: there is no back-pressure. A frame result is presented as a
// single-cycle strobe (DATA_VALID, or PAR_ERR/STP_ERR) one cycle after the
// frame-end cycle; P_DATA is updated in the same cycle and holds until the
// next frame end. The consumer must take it on that cycle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output rx_state_e             DBG_STATE
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]        B_ONE    = BCW'(1);
  localparam logic [BCW-1:0]        LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] E_ONE    = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P8       = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] P16      = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] P32      = PRESCALE_W'(32);
  localparam logic [PRESCALE_W-1:0] P_FB     = PRESCALE_W'(PRESCALE_FALLBACK);

  logic                  sync1_q, rx_s_q;
  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_flag_q, par_flag_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;

  logic smp_bit, smp_valid, last_edge, bit_done, p_legal, exp_par, begin_frame;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .rx_s_i     (rx_s_q),
    .edge_cnt_i (edge_cnt_q),
    .prescale_i (prescale_q),
    .bit_o      (smp_bit),
    .valid_o    (smp_valid)
  );

  assign last_edge = (edge_cnt_q == prescale_q - E_ONE);
  assign bit_done  = last_edge && smp_valid;
  assign p_legal   = (PRESCALE == P8) || (PRESCALE == P16) || (PRESCALE == P32);
  assign exp_par   = (par_typ_q == ODD_PAR) ? ~^shreg_q : ^shreg_q;

  // Bring the asynchronous serial line into the CLK domain.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      rx_s_q  <= sync1_q;
    end
  end

  // Frame FSM: next state, counters, shift register, checks and strobes.
  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = last_edge ? '0 : edge_cnt_q + E_ONE;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_flag_d  = par_flag_q;
    p_data_d    = p_data_q;
    dv_d        = 1'b0;
    perr_d      = 1'b0;
    serr_d      = 1'b0;
    prescale_d  = prescale_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    begin_frame = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        par_flag_d = 1'b0;
        if (!rx_s_q) begin
          state_d     = RX_START;
          begin_frame = 1'b1;
        end
      end
      RX_START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (bit_done) state_d = smp_bit ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (bit_done) begin
          shreg_d[bit_cnt_q] = smp_bit;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? RX_PARITY : RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + B_ONE;
          end
        end
      end
      RX_PARITY: begin
        if (bit_done) begin
          par_flag_d = (smp_bit != exp_par);
          state_d    = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_done) begin
          p_data_d   = shreg_q;
          dv_d       = !par_flag_q && smp_bit;
          perr_d     = par_flag_q;
          serr_d     = !smp_bit;
          par_flag_d = 1'b0;
          // Line already low here means the next start bit began: no idle gap.
          if (!rx_s_q) begin
            state_d     = RX_START;
            begin_frame = 1'b1;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
    // Frame configuration is frozen for the whole frame from its start.
    if (begin_frame) begin
      prescale_d = p_legal ? PRESCALE : P_FB;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      edge_cnt_d = '0;
    end
  end

  // State, counter, data and strobe registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= RX_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      prescale_q <= P_FB;
      par_en_q   <= 1'b0;
      par_typ_q  <= EVEN_PAR;
      shreg_q    <= '0;
      par_flag_q <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      shreg_q    <= shreg_d;
      par_flag_q <= par_flag_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = perr_q;
  assign STP_ERR    = serr_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-written corner sequences and
// random frames. Every frame result is predicted (cycle stamp, data, flags)
// and matched against the strobes seen on the outputs.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int EW = 32 + DW + 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] PRESCALE = PW'(8);
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID, PAR_ERR, STP_ERR;
  rx_state_e     DBG_STATE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected frame results: {cycle stamp, data, valid, par_err, stp_err}.
  logic [EW-1:0] exp_q[$];

  typedef struct {
    int            p;
    bit            pe;
    bit            pt;
    logic [DW-1:0] d;
    bit            pbit;
    bit            stopb;
    int            glitch;
    int            gap;
    bit            ev, ep, es;
  } vec_t;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .DBG_STATE  (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic bit good_parity(input logic [DW-1:0] d, input bit pt);
    int ones;
    ones = $countones(d);
    return pt ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  function automatic logic [2:0] model_flags(input logic [DW-1:0] d, input bit pe, input bit pt,
                                             input bit pbit, input bit stopb);
    bit perr, serr;
    perr = pe && (pbit != good_parity(d, pt));
    serr = (stopb == 1'b0);
    return {!perr && !serr, perr, serr};
  endfunction

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // Scoreboard: every strobe cycle must match the oldest expected frame.
  always @(negedge CLK) begin
    logic [EW-1:0] got, e;
    if (DATA_VALID || PAR_ERR || STP_ERR) begin
      got = {32'(cyc), P_DATA, DATA_VALID, PAR_ERR, STP_ERR};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got stamp=%0d data=%h v/p/s=%b required no strobe",
                 got[EW-1:DW+3], got[DW+2:3], got[2:0]);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL frame_result: got stamp=%0d data=%h v/p/s=%b required stamp=%0d data=%h v/p/s=%b",
                   got[EW-1:DW+3], got[DW+2:3], got[2:0], e[EW-1:DW+3], e[DW+2:3], e[2:0]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Sends one frame starting at the current negedge and registers its expected
  // result. Configuration inputs are scrambled mid-start-bit to show they are
  // ignored once the frame has begun.
  task automatic send_frame(input int p_prog, input bit pe, input bit pt, input logic [DW-1:0] d,
                            input bit pbit, input bit stopb, input int glitch, input logic [2:0] flags);
    int p, nb;
    p  = (p_prog == 8 || p_prog == 16 || p_prog == 32) ? p_prog : 8;
    nb = 2 + DW + (pe ? 1 : 0);
    PRESCALE = PW'(p_prog);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    RX_IN    = 1'b0;
    exp_q.push_back({32'(cyc + nb * p + 3), d, flags});
    repeat (p / 2) @(negedge CLK);
    PAR_TYP  = ~pt;
    PAR_EN   = 1'($urandom_range(0, 1));
    PRESCALE = PW'($urandom_range(8, 40));
    repeat (p - p / 2) @(negedge CLK);
    for (int i = 0; i < DW; i++) begin
      RX_IN = d[i];
      if (i == glitch) begin
        repeat (p / 2) @(negedge CLK);
        RX_IN = ~d[i];
        @(negedge CLK);
        RX_IN = d[i];
        repeat (p - p / 2 - 1) @(negedge CLK);
      end else begin
        repeat (p) @(negedge CLK);
      end
    end
    if (pe) begin
      RX_IN = pbit;
      repeat (p) @(negedge CLK);
    end
    RX_IN = stopb;
    repeat (p) @(negedge CLK);
    RX_IN = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d frames outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[10];

  initial begin
    vecs[0] = '{8,  0, EVEN_PAR, 8'hA5, 0, 1, -1, 10, 1, 0, 0};
    vecs[1] = '{16, 1, EVEN_PAR, 8'h3C, 0, 1, -1, 10, 1, 0, 0};
    vecs[2] = '{16, 1, EVEN_PAR, 8'h3C, 1, 1, -1, 10, 0, 1, 0};
    vecs[3] = '{32, 1, ODD_PAR,  8'h01, 0, 1, -1, 10, 1, 0, 0};
    vecs[4] = '{32, 1, ODD_PAR,  8'h01, 0, 0, -1, 10, 0, 0, 1};
    vecs[5] = '{8,  0, EVEN_PAR, 8'h55, 0, 1, -1, 0,  1, 0, 0};
    vecs[6] = '{8,  0, EVEN_PAR, 8'hAA, 0, 1, -1, 10, 1, 0, 0};
    vecs[7] = '{16, 1, ODD_PAR,  8'hC3, 0, 0, -1, 10, 0, 1, 1};
    vecs[8] = '{20, 0, EVEN_PAR, 8'h96, 0, 1, -1, 10, 1, 0, 0};
    vecs[9] = '{16, 0, EVEN_PAR, 8'h5A, 0, 1, 3,  10, 1, 0, 0};

    // Reset state.
    repeat (3) @(negedge CLK);
    check("reset_p_data", 32'(P_DATA), 32'h0);
    check("reset_data_valid", 32'(DATA_VALID), 32'h0);
    check("reset_par_err", 32'(PAR_ERR), 32'h0);
    check("reset_stp_err", 32'(STP_ERR), 32'h0);
    check("reset_state", 32'(DBG_STATE), 32'(RX_IDLE));
    RST = 1'b1;
    idle(10);

    // Directed table.
    foreach (vecs[i]) begin
      send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d, vecs[i].pbit, vecs[i].stopb,
                 vecs[i].glitch, {vecs[i].ev, vecs[i].ep, vecs[i].es});
      idle(vecs[i].gap);
    end
    wait_drain("table_drain", 1000);
    check("p_data_hold", 32'(P_DATA), 32'h5A);

    // Start glitch: 3 low cycles at P=16 must not start a frame.
    PRESCALE = PW'(16);
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    idle(40);
    check("glitch_state", 32'(DBG_STATE), 32'(RX_IDLE));
    check("glitch_p_data", 32'(P_DATA), 32'h5A);

    // Reset in the middle of the data bits.
    PRESCALE = PW'(8);
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    RX_IN = 1'b1; repeat (8) @(negedge CLK);
    RX_IN = 1'b0; repeat (8) @(negedge CLK);
    RX_IN = 1'b1; repeat (8) @(negedge CLK);
    check("mid_frame_state", 32'(DBG_STATE), 32'(RX_DATA));
    RST = 1'b0;
    RX_IN = 1'b1;
    #1;
    check("mid_rst_p_data", 32'(P_DATA), 32'h0);
    check("mid_rst_valid", 32'(DATA_VALID), 32'h0);
    check("mid_rst_errs", 32'({PAR_ERR, STP_ERR}), 32'h0);
    check("mid_rst_state", 32'(DBG_STATE), 32'(RX_IDLE));
    @(negedge CLK);
    RST = 1'b1;
    idle(20);
    send_frame(16, 1, EVEN_PAR, 8'h7E, good_parity(8'h7E, EVEN_PAR), 1, -1, 3'b100);
    idle(5);
    wait_drain("post_reset_drain", 1000);

    // Random frames against the model, including back-to-back ones.
    for (int n = 0; n < 25; n++) begin
      int p; bit pe, pt, pbit, stopb; logic [DW-1:0] d;
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pe    = 1'($urandom_range(0, 1));
      pt    = 1'($urandom_range(0, 1));
      d     = DW'($urandom_range(0, 255));
      pbit  = good_parity(d, pt) ^ ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 4) != 0);
      send_frame(p, pe, pt, d, pbit, stopb, -1, model_flags(d, pe, pt, pbit, stopb));
      idle($urandom_range(0, 3));
    end
    wait_drain("random_drain", 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got no completion required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
